accu_feeder: RTL
================

Name: accu_feeder

Overview:
- Transmit-side counterpart of the beat accumulator: feeds its 8-bit valid-qualified input stream.
- Accepts whole words on a valid/ready handshake, buffers them in a 2-entry FIFO, and serialises each word into BEATS contiguous 8-bit beats, least-significant byte first.
- Computes the expected sum of each word's beats alongside, so a bench or checker can compare it against the accumulator's result.

Parameters:
- BEATS, 4, beats per word. Must be >= 2.
- DW, 8, beat width in bits.
- SW, 10, sum width. Must be >= DW + clog2(BEATS).
- GAP_CYCLES, 1, idle cycles (valid_out low) between consecutive words. 0 means back-to-back; range 0..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- word_in  input  BEATS*DW  word to send; beat k is bits [k*DW +: DW].
- word_valid  input  1  word_in is valid.
- word_ready  output  1  FIFO can accept a word this cycle.
- data_out  output  DW  current beat.
- valid_out  output  1  data_out is valid.
- sum_exp  output  SW  zero-extended sum of all beats of the word just sent.
- sum_valid  output  1  one-cycle qualifier for sum_exp.
- busy  output  1  high if the FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs reset to 0 except word_ready, which resets to 1. FIFO is emptied, FSM goes to IDLE, beat counter is 0. Asserting rst mid-word drops valid_out immediately; the partial word is discarded.
- FIFO:
  - 2 entries. word_ready = not full.
  - A push occurs on word_valid && word_ready.
  - A push and a pop in the same cycle are legal when the FIFO is non-full.
  - When full, word_ready is low; there is no pass-through.
  - Total capacity is 3 words: 2 in the FIFO plus 1 in the shift register.
- IDLE:
  - If the FIFO is non-empty: pop the head into the shift register, clear the running sum, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - valid_out = 1. data_out = beat[cnt].
  - Each cycle, sum += beat[cnt] and cnt increments.
  - On cnt == BEATS-1 (the last beat):
    - sum_exp is the full word sum, registered so that sum_valid pulses in the same cycle as the last beat.
    - cnt returns to 0.
    - Next state is GAP if GAP_CYCLES > 0.
    - If GAP_CYCLES == 0 and the FIFO is non-empty: pop and stay in SEND, giving the next word's beat 0 in the next cycle.
    - Otherwise go to IDLE.
- GAP:
  - valid_out = 0. Counts GAP_CYCLES cycles.
  - Then pops and goes to SEND if the FIFO is non-empty, else goes to IDLE.
- Beats of one word are always contiguous. valid_out never deasserts mid-word, because the downstream accumulator discards partial groups on a gap.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. Beat 0 is visible after edge N+2, and the last beat after edge N+1+BEATS.
- data_out holds its last value when valid_out = 0. sum_exp holds its value until the next word completes.
- Arithmetic: beats are unsigned and the sum wraps modulo 2^SW. This cannot occur at the defaults (maximum 1020 < 1024).
- busy is low only when the FIFO is empty and the FSM is in IDLE.

Test Plan:
- Single word 0x04030201 pushed into an idle block -> valid_out high for exactly 4 cycles with data_out 0x01, 0x02, 0x03, 0x04. sum_valid pulses with beat 0x04, sum_exp = 10. Then busy drops.
- Word 0xFFFFFFFF -> four beats of 0xFF, sum_exp = 1020 (0x3FC), no wrap.
- word_valid held high with 5 distinct words -> word_ready low after 3 accepted. Beat groups are separated by exactly 1 idle cycle (GAP_CYCLES = 1). All 5 words emerge in order with correct sums.
- GAP_CYCLES = 0 with two queued words -> 8 consecutive valid_out cycles. sum_valid pulses on beat 4 and beat 8.
- rst asserted during beat 2 of a word, with 1 word queued -> valid_out, sum_valid and busy drop immediately, word_ready = 1. After release no beats appear until a new push, so the queued word is lost.
- Push and pop in the same cycle with the FIFO at 1 entry -> occupancy stays 1, no word lost or duplicated, order preserved.

Source files
------------

// File: rtl/accu_feeder.sv
// Word-to-beat serialiser feeding the beat accumulator: 2-entry word FIFO, LSB-first
// beat shifter with configurable inter-word gap, and a running expected-sum output.
module accu_feeder #(
    parameter int BEATS      = 4,
    parameter int DW         = 8,
    parameter int SW         = 10,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BEATS*DW-1:0]   word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [DW-1:0]         data_out,
    output logic                  valid_out,
    output logic [SW-1:0]         sum_exp,
    output logic                  sum_valid,
    output logic                  busy
);

    localparam int WW = BEATS * DW;
    localparam int CW = $clog2(BEATS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [WW-1:0]   fifo_mem [2];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [WW-1:0]   word_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      gap_cnt_reg;
    logic [SW-1:0]   sum_reg;

    logic [DW-1:0]   data_out_reg;
    logic            valid_out_reg;
    logic [SW-1:0]   sum_exp_reg;
    logic            sum_valid_reg;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            last_beat;

    logic [DW-1:0]   beats [BEATS];
    logic [DW-1:0]   cur_beat;
    logic [SW-1:0]   beat_ext;
    logic [SW-1:0]   sum_plus;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beats[gi] = word_reg[gi*DW +: DW];
        end
    endgenerate

    assign cur_beat   = beats[cnt_reg];
    assign beat_ext   = {{(SW-DW){1'b0}}, cur_beat};
    assign sum_plus   = sum_reg + beat_ext;
    assign last_beat  = (cnt_reg == CNT_LAST);

    assign fifo_full  = (count_reg == 2'd2);
    assign fifo_empty = (count_reg == 2'd0);
    assign word_ready = !fifo_full;
    assign push       = word_valid && !fifo_full;

    assign data_out   = data_out_reg;
    assign valid_out  = valid_out_reg;
    assign sum_exp    = sum_exp_reg;
    assign sum_valid  = sum_valid_reg;
    assign busy       = !fifo_empty || (state_reg != S_IDLE);

    // Next-state and pop decision; a pop always lands the FIFO head in the shifter.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (last_beat) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = S_GAP;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = S_SEND;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Storage array carries no reset so it maps onto plain RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= word_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            state_reg     <= S_IDLE;
            word_reg      <= '0;
            cnt_reg       <= '0;
            gap_cnt_reg   <= 4'd0;
            sum_reg       <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
            sum_exp_reg   <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_reg + 2'(push) - 2'(pop);
            valid_out_reg <= (state_reg == S_SEND);
            sum_valid_reg <= 1'b0;

            if (push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end

            if (state_reg == S_SEND) begin
                data_out_reg <= cur_beat;
                sum_reg      <= sum_plus;
                cnt_reg      <= last_beat ? '0 : cnt_reg + 1'b1;
                if (last_beat) begin
                    sum_exp_reg   <= sum_plus;
                    sum_valid_reg <= 1'b1;
                end
            end

            if (state_reg == S_GAP) begin
                gap_cnt_reg <= (gap_cnt_reg == GAP_LAST) ? 4'd0 : gap_cnt_reg + 4'd1;
            end

            // A pop overrides the SEND bookkeeping so back-to-back words start clean.
            if (pop) begin
                word_reg   <= fifo_mem[rd_ptr_reg];
                rd_ptr_reg <= !rd_ptr_reg;
                sum_reg    <= '0;
                cnt_reg    <= '0;
            end
        end
    end

endmodule
